// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-engine state
// encoding and the default geometry used by the core top level.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: packed read ports, two
// write ports, clear request, idle flag and a debug view of the clear FSM.
interface regfile_mp_if #(
    parameter int XLEN  = regfile_pkg::XLEN_DEF,
    parameter int NREGS = regfile_pkg::NREGS_DEF,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    // Handshake: READY=1 means writes are taken at the next rising edge; while
    // READY=0 a clear is running and WE0/WE1/CLR are ignored. Reads never stall.
    logic [NREAD*AW-1:0]   RA;
    logic [NREAD*XLEN-1:0] RD;
    logic                  WE0;
    logic [AW-1:0]         WA0;
    logic [XLEN-1:0]       WD0;
    logic                  WE1;
    logic [AW-1:0]         WA1;
    logic [XLEN-1:0]       WD1;
    logic                  CLR;
    logic                  READY;
    regfile_pkg::rf_state_e state;

    modport master (
        output RA, WE0, WA0, WD0, WE1, WA1, WD1, CLR,
        input  RD, READY, state
    );

    modport slave (
        input  RA, WE0, WA0, WD0, WE1, WA1, WD1, CLR,
        output RD, READY, state
    );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks entries 0..NREGS-1 one per cycle and holds
// READY low for exactly NREGS cycles.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    output logic          ready,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output rf_state_e     state
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    logic [AW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RF_IDLE;
            cnt   <= '0;
            ready <= 1'b1;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clr) begin
                        state <= RF_CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                RF_CLEAR: begin
                    // CLR is not looked at here, so a request mid-clear cannot restart it
                    if (cnt == LAST) begin
                        state <= RF_IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    state <= RF_IDLE;
                    cnt   <= '0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign clr_en   = (state == RF_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NREAD-read / 2-write register file with optional write-to-read
// bypass, optional hardwired-zero entry 0 and a sequential clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         CLK,
    input  logic         RST,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]       mem [NREGS];
    logic                  ready;
    logic                  clr_en;
    logic [AW-1:0]         clr_addr;
    rf_state_e             state;
    logic                  wr0_ok, wr1_ok, wr0_take;
    logic [AW-1:0]         ra;
    logic [XLEN-1:0]       rd;
    logic [NREAD*XLEN-1:0] rd_all;

    function automatic logic writable(input logic [AW-1:0] a);
        return (32'(a) < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    regfile_clr_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_fsm (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (bus.CLR),
        .ready    (ready),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .state    (state)
    );

    assign wr0_ok   = ready && bus.WE0 && writable(bus.WA0);
    assign wr1_ok   = ready && bus.WE1 && writable(bus.WA1);
    // Port 1 wins a same-address collision, so port 0 simply stands down
    assign wr0_take = wr0_ok && !(wr1_ok && (bus.WA1 == bus.WA0));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr0_take) mem[bus.WA0] <= bus.WD0;
            if (wr1_ok)   mem[bus.WA1] <= bus.WD1;
        end
    end

    always_comb begin
        ra     = '0;
        rd     = '0;
        rd_all = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = bus.RA[i*AW +: AW];
            rd = '0;
            if (32'(ra) < 32'(NREGS)) rd = mem[ra];
            if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
            // wrN_ok already folds in READY and writability of the target
            if (BYPASS != 0) begin
                if (wr0_ok && (bus.WA0 == ra)) rd = bus.WD0;
                if (wr1_ok && (bus.WA1 == ra)) rd = bus.WD1;
            end
            rd_all[i*XLEN +: XLEN] = rd;
        end
    end

    assign bus.RD    = rd_all;
    assign bus.READY = ready;
    assign bus.state = state;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 32x2R bypassing instance and a 24x4R non-bypassing
// instance driven by directed vectors, checked through an expected queue.
module tb_regfile_mp;
    import regfile_pkg::*;

    typedef struct packed {
        int          dut;   // 0 = instance A, 1 = instance B
        int          sel;   // 0..3 read port, 4 = READY, 5 = state
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    exp_t  exp_q[$];
    string name_q[$];

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_a ();
    regfile_mp_if #(.XLEN(32), .NREGS(24), .NREAD(4)) bus_b ();

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus_a)
    );

    regfile_mp #(
        .XLEN(32), .NREGS(24), .NREAD(4), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int dut, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.dut = dut;
        e.sel = sel;
        e.val = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle_a();
        bus_a.WE0 = 1'b0; bus_a.WA0 = '0; bus_a.WD0 = '0;
        bus_a.WE1 = 1'b0; bus_a.WA1 = '0; bus_a.WD1 = '0;
        bus_a.CLR = 1'b0;
    endtask

    task automatic idle_b();
        bus_b.WE0 = 1'b0; bus_b.WA0 = '0; bus_b.WD0 = '0;
        bus_b.WE1 = 1'b0; bus_b.WA1 = '0; bus_b.WD1 = '0;
        bus_b.CLR = 1'b0;
    endtask

    task automatic ra_a(input int p0, input int p1);
        bus_a.RA = {5'(p1), 5'(p0)};
    endtask

    task automatic ra_b(input int p0, input int p1, input int p2, input int p3);
        bus_b.RA = {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
    endtask

    function automatic logic [31:0] get_act(input int dut, input int sel);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        if (dut == 0) begin
            if (sel < 2)       r = bus_a.RD[sel*32 +: 32];
            else if (sel == 4) r = {31'd0, bus_a.READY};
            else if (sel == 5) r = {31'd0, bus_a.state};
        end else begin
            if (sel < 4)       r = bus_b.RD[sel*32 +: 32];
            else if (sel == 4) r = {31'd0, bus_b.READY};
            else if (sel == 5) r = {31'd0, bus_b.state};
        end
        return r;
    endfunction

    // scoreboard monitor: every expectation is checked at the next falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [31:0] act;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = get_act(e.dut, e.sel);
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: dut%0d sel%0d got %h expected %h", nm, e.dut, e.sel, act, e.val);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle_a();
        idle_b();
        ra_a(0, 0);
        ra_b(0, 0, 0, 0);

        // reset state
        step();
        expect_val(0, 4, 32'd1, "reset_ready_a");
        expect_val(0, 0, 32'd0, "reset_rd_a");
        expect_val(0, 5, 32'(RF_IDLE), "reset_state_a");
        step();
        rst_n = 1'b1;

        // all addresses read zero after reset
        for (int a = 0; a < 32; a++) begin
            step();
            ra_a(a, 31 - a);
            ra_b(a % 24, (a + 7) % 24, (a + 13) % 24, 23 - (a % 24));
            expect_val(0, 0, 32'd0, "init_a_p0");
            expect_val(0, 1, 32'd0, "init_a_p1");
            expect_val(1, 3, 32'd0, "init_b_p3");
            if (a == 0) expect_val(0, 4, 32'd1, "init_ready_a");
        end

        // bypass vs no bypass
        step();
        bus_a.WE0 = 1'b1; bus_a.WA0 = 5'd5; bus_a.WD0 = 32'hDEAD_BEEF;
        bus_b.WE0 = 1'b1; bus_b.WA0 = 5'd5; bus_b.WD0 = 32'hDEAD_BEEF;
        ra_a(5, 6);
        ra_b(5, 0, 0, 0);
        expect_val(0, 0, 32'hDEAD_BEEF, "bypass_a");
        expect_val(0, 1, 32'd0, "bypass_other_a");
        expect_val(1, 0, 32'd0, "nobypass_b");
        step();
        idle_a(); idle_b();
        expect_val(0, 0, 32'hDEAD_BEEF, "stored_a");
        expect_val(1, 0, 32'hDEAD_BEEF, "stored_b");

        // same-address collision: port 1 wins
        step();
        bus_a.WE0 = 1'b1; bus_a.WA0 = 5'd7; bus_a.WD0 = 32'h11;
        bus_a.WE1 = 1'b1; bus_a.WA1 = 5'd7; bus_a.WD1 = 32'h22;
        bus_b.WE0 = 1'b1; bus_b.WA0 = 5'd7; bus_b.WD0 = 32'h11;
        bus_b.WE1 = 1'b1; bus_b.WA1 = 5'd7; bus_b.WD1 = 32'h22;
        ra_a(7, 7);
        ra_b(7, 0, 0, 0);
        expect_val(0, 0, 32'h22, "collide_bypass_a");
        expect_val(1, 0, 32'd0, "collide_nobypass_b");
        step();
        idle_a(); idle_b();
        expect_val(0, 1, 32'h22, "collide_stored_a");
        expect_val(1, 0, 32'h22, "collide_stored_b");

        // entry 0 hardwired to zero, no bypass for it either
        step();
        bus_a.WE0 = 1'b1; bus_a.WA0 = 5'd0; bus_a.WD0 = 32'hFF;
        ra_a(0, 5);
        expect_val(0, 0, 32'd0, "zero_bypass_a");
        step();
        idle_a();
        expect_val(0, 0, 32'd0, "zero_stored_a");
        expect_val(0, 1, 32'hDEAD_BEEF, "keep_r5_a");

        // instance B: out-of-range write dropped, four read ports
        step();
        bus_b.WE0 = 1'b1; bus_b.WA0 = 5'd1; bus_b.WD0 = 32'h101;
        bus_b.WE1 = 1'b1; bus_b.WA1 = 5'd2; bus_b.WD1 = 32'h202;
        step();
        bus_b.WE0 = 1'b1; bus_b.WA0 = 5'd3;  bus_b.WD0 = 32'h303;
        bus_b.WE1 = 1'b1; bus_b.WA1 = 5'd23; bus_b.WD1 = 32'h2323;
        step();
        bus_b.WE0 = 1'b1; bus_b.WA0 = 5'd25; bus_b.WD0 = 32'hBAD;
        bus_b.WE1 = 1'b0;
        ra_b(1, 2, 3, 23);
        expect_val(1, 0, 32'h101, "b_r1");
        expect_val(1, 1, 32'h202, "b_r2");
        expect_val(1, 2, 32'h303, "b_r3");
        expect_val(1, 3, 32'h2323, "b_r23");
        step();
        idle_b();
        ra_b(25, 5, 7, 24);
        expect_val(1, 0, 32'd0, "b_r25_oob");
        expect_val(1, 1, 32'hDEAD_BEEF, "b_r5");
        expect_val(1, 2, 32'h22, "b_r7");
        expect_val(1, 3, 32'd0, "b_r24_oob");

        // fill A with index values, then run a full clear
        for (int k = 1; k < 32; k++) begin
            step();
            bus_a.WE0 = 1'b1; bus_a.WA0 = 5'(k); bus_a.WD0 = 32'(k);
        end
        step();
        idle_a();
        bus_a.CLR = 1'b1;
        ra_a(3, 31);
        expect_val(0, 0, 32'd3, "prefill_r3");
        expect_val(0, 1, 32'd31, "prefill_r31");
        expect_val(0, 4, 32'd1, "preclear_ready");
        for (int c = 0; c < 32; c++) begin
            step();
            idle_a();
            if (c == 5) bus_a.CLR = 1'b1;
            expect_val(0, 4, 32'd0, "clear_ready_low");
            if (c == 0) expect_val(0, 5, 32'(RF_CLEAR), "clear_state");
            if (c == 10) begin
                bus_a.WE0 = 1'b1; bus_a.WA0 = 5'd3; bus_a.WD0 = 32'h333;
                ra_a(3, 9);
                expect_val(0, 0, 32'd0, "clear_no_bypass_r3");
            end else begin
                ra_a(c, (c == 0) ? 0 : c - 1);
                expect_val(0, 0, 32'(c), "clear_not_yet");
            end
            expect_val(0, 1, 32'd0, "clear_done_entry");
        end
        step();
        idle_a();
        ra_a(3, 31);
        expect_val(0, 4, 32'd1, "clear_exit_ready");
        expect_val(0, 0, 32'd0, "clear_r3_dropped");
        expect_val(0, 1, 32'd0, "clear_r31");

        // reset in the middle of a clear
        step();
        bus_a.WE0 = 1'b1; bus_a.WA0 = 5'd20; bus_a.WD0 = 32'h2020;
        bus_a.WE1 = 1'b1; bus_a.WA1 = 5'd25; bus_a.WD1 = 32'h2525;
        bus_a.CLR = 1'b1;
        step();
        idle_a();
        ra_a(20, 25);
        expect_val(0, 0, 32'h2020, "clr_cycle_write_r20");
        expect_val(0, 1, 32'h2525, "clr_cycle_write_r25");
        expect_val(0, 4, 32'd0, "clr2_ready_low");
        repeat (9) step();
        expect_val(0, 0, 32'h2020, "clr2_r20_kept");
        step();
        rst_n = 1'b0;
        #1;
        expect_val(0, 4, 32'd1, "midreset_ready");
        expect_val(0, 5, 32'(RF_IDLE), "midreset_state");
        expect_val(0, 0, 32'd0, "midreset_r20");
        expect_val(0, 1, 32'd0, "midreset_r25");
        step();
        rst_n = 1'b1;
        step();
        bus_a.WE0 = 1'b1; bus_a.WA0 = 5'd12; bus_a.WD0 = 32'h00C0_FFEE;
        ra_a(12, 20);
        expect_val(0, 0, 32'h00C0_FFEE, "post_reset_bypass");
        expect_val(0, 1, 32'd0, "post_reset_r20");
        step();
        idle_a();
        expect_val(0, 0, 32'h00C0_FFEE, "post_reset_stored");
        expect_val(0, 4, 32'd1, "post_reset_ready");

        // let the monitor drain, then confirm nothing was left unchecked
        step();
        step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
